rr_shi_unload_16: RTL and testbench



---
 rtl/rr_shi_unload_16.sv | 148 ++++++++++++++
 tb/tb_rr_shi_unload_16.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_shi_unload_16.sv
// ---------------------------------------------------------------------------
// rr_shi_unload_16
//
// Unloading counterpart of the 256-bit right-shift load register used in the
// modular-division datapath. A WIDTH-bit operand is loaded in parallel and
// streamed out as WORD-bit words, least-significant word first. This matches
// the order in which the load register is filled, so a word stream
// round-trips unchanged. A 1-bit left-shift mode exports the MSB through
// bit_out. It mirrors the load register's right-shift-with-bit256 mode.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset
//   load        parallel load of din into the shift register (IDLE only)
//   din         WIDTH-bit parallel data in
//   start       begin a word unload of the current register content (IDLE only)
//   shl1        left shift by one bit (IDLE only)
//   bit0_in     bit shifted into the LSB on shl1
//   bit_out     MSB shifted out by the most recent shl1
//   dout        current output word (low word of the register)
//   dout_valid  dout holds a word
//   dout_ready  consumer accepts dout
//   busy        unload in progress
//   done        one-cycle pulse after the last word is accepted
//   regout      shift-register contents
// ---------------------------------------------------------------------------
module rr_shi_unload_16 #(
    parameter int WIDTH = 256,
    parameter int WORD  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             start,
    input  logic             shl1,
    input  logic             bit0_in,
    output logic             bit_out,
    output logic [WORD-1:0]  dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] regout
);

    localparam int NWORDS = WIDTH / WORD;
    localparam int CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NWORDS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   sr, sr_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               bit_out_nxt;
    logic               done_nxt;
    logic               dout_valid_nxt;
    logic               busy_nxt;
    logic               hs;

    // A word is consumed only while it is actually being offered.
    assign hs = (state == SEND) && dout_valid && dout_ready;

    // -----------------------------------------------------------------------
    // Next-state and next-value logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt      = state;
        sr_nxt         = sr;
        cnt_nxt        = cnt;
        bit_out_nxt    = bit_out;
        done_nxt       = 1'b0;
        dout_valid_nxt = dout_valid;
        busy_nxt       = busy;

        case (state)
            IDLE: begin
                // Strict priority load > start > shl1; losers are dropped.
                if (load) begin
                    sr_nxt = din;
                end else if (start) begin
                    state_nxt      = SEND;
                    cnt_nxt        = '0;
                    dout_valid_nxt = 1'b1;
                    busy_nxt       = 1'b1;
                end else if (shl1) begin
                    sr_nxt      = {sr[WIDTH-2:0], bit0_in};
                    bit_out_nxt = sr[WIDTH-1];
                end
            end

            SEND: begin
                // Rotate rather than shift, so that after NWORDS handshakes
                // the register is back to its value at start.
                if (hs) begin
                    sr_nxt = {sr[WORD-1:0], sr[WIDTH-1:WORD]};
                    if (cnt == CNT_LAST) begin
                        state_nxt      = IDLE;
                        cnt_nxt        = '0;
                        dout_valid_nxt = 1'b0;
                        busy_nxt       = 1'b0;
                        done_nxt       = 1'b1;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end

            default: begin
                state_nxt      = IDLE;
                dout_valid_nxt = 1'b0;
                busy_nxt       = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State and data registers. A reset mid-unload discards the register
    // content and suppresses done.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            sr         <= '0;
            cnt        <= '0;
            bit_out    <= 1'b0;
            done       <= 1'b0;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            sr         <= sr_nxt;
            cnt        <= cnt_nxt;
            bit_out    <= bit_out_nxt;
            done       <= done_nxt;
            dout_valid <= dout_valid_nxt;
            busy       <= busy_nxt;
        end
    end

    assign dout   = sr[WORD-1:0];
    assign regout = sr;

endmodule

// File: tb/tb_rr_shi_unload_16.sv
// ---------------------------------------------------------------------------
// tb_rr_shi_unload_16
//
// Directed bench for rr_shi_unload_16: reset state, streaming unload,
// backpressure, 1-bit left shift, ignored requests during an unload,
// mid-unload reset, load/start collision and back-to-back unloads.
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
// ---------------------------------------------------------------------------
module tb_rr_shi_unload_16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         load;
    logic [255:0] din;
    logic         start;
    logic         shl1;
    logic         bit0_in;
    logic         bit_out;
    logic [15:0]  dout;
    logic         dout_valid;
    logic         dout_ready;
    logic         busy;
    logic         done;
    logic [255:0] regout;

    int checks   = 0;
    int failures = 0;

    logic [255:0] data_a;
    logic [255:0] data_b;

    rr_shi_unload_16 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .din        (din),
        .start      (start),
        .shl1       (shl1),
        .bit0_in    (bit0_in),
        .bit_out    (bit_out),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy),
        .done       (done),
        .regout     (regout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [255:0] value);
        din  = value;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if (regout !== 256'd0 || dout_valid !== 1'b0 || busy !== 1'b0 ||
            done !== 1'b0 || bit_out !== 1'b0 || dout !== 16'h0000) begin
            failures++;
            $display("FAIL reset_state regout=%h valid=%b busy=%b done=%b bit_out=%b required zeros",
                     regout, dout_valid, busy, done, bit_out);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_stream();
        do_load(data_a);
        checks++;
        if (regout !== data_a) begin
            failures++;
            $display("FAIL stream_load regout=%h required %h", regout, data_a);
        end
        dout_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (dout_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0 ||
                dout !== 16'(16'h1000 + k)) begin
                failures++;
                $display("FAIL stream_word%0d dout=%h valid=%b busy=%b done=%b required %h/1/1/0",
                         k, dout, dout_valid, busy, done, 16'(16'h1000 + k));
            end
            tick();
        end
        checks++;
        if (done !== 1'b1 || dout_valid !== 1'b0 || busy !== 1'b0 || regout !== data_a) begin
            failures++;
            $display("FAIL stream_done done=%b valid=%b busy=%b regout=%h required 1/0/0/%h",
                     done, dout_valid, busy, regout, data_a);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL stream_done_pulse done=%b required 0", done);
        end
    endtask

    task automatic test_backpressure();
        int exp_idx;
        do_load(data_a);
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_idx = 0;
        for (int cyc = 0; cyc < 100 && exp_idx < 16; cyc++) begin
            dout_ready = ((cyc % 3) == 0);
            checks++;
            if (dout_valid !== 1'b1 || done !== 1'b0 || dout !== 16'(16'h1000 + exp_idx)) begin
                failures++;
                $display("FAIL bp_word%0d cyc=%0d dout=%h valid=%b done=%b required %h/1/0",
                         exp_idx, cyc, dout, dout_valid, done, 16'(16'h1000 + exp_idx));
            end
            tick();
            if (dout_ready) exp_idx++;
        end
        dout_ready = 1'b1;
        checks++;
        if (exp_idx !== 16 || done !== 1'b1 || busy !== 1'b0 || regout !== data_a) begin
            failures++;
            $display("FAIL bp_done words=%0d done=%b busy=%b regout=%h required 16/1/0/%h",
                     exp_idx, done, busy, regout, data_a);
        end
        tick();
    endtask

    task automatic test_shl1();
        logic [255:0] v;
        v = '0;
        v[255] = 1'b1;
        v[0] = 1'b1;
        do_load(v);
        shl1 = 1'b1;
        bit0_in = 1'b1;
        tick();
        checks++;
        if (regout !== 256'd3 || bit_out !== 1'b1) begin
            failures++;
            $display("FAIL shl1_first regout=%h bit_out=%b required 3/1", regout, bit_out);
        end
        shl1 = 1'b0;
        bit0_in = 1'b0;
        tick();
        checks++;
        if (regout !== 256'd3 || bit_out !== 1'b1) begin
            failures++;
            $display("FAIL shl1_hold regout=%h bit_out=%b required 3/1", regout, bit_out);
        end
        shl1 = 1'b1;
        tick();
        shl1 = 1'b0;
        checks++;
        if (regout !== 256'd6 || bit_out !== 1'b0) begin
            failures++;
            $display("FAIL shl1_second regout=%h bit_out=%b required 6/0", regout, bit_out);
        end
    endtask

    task automatic test_ignore_in_send();
        do_load(data_a);
        dout_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (k == 3) begin
                din = '1;
                load = 1'b1;
                start = 1'b1;
                shl1 = 1'b1;
                bit0_in = 1'b1;
            end
            checks++;
            if (dout_valid !== 1'b1 || dout !== 16'(16'h1000 + k)) begin
                failures++;
                $display("FAIL ign_word%0d dout=%h valid=%b required %h/1",
                         k, dout, dout_valid, 16'(16'h1000 + k));
            end
            tick();
            load = 1'b0;
            start = 1'b0;
            shl1 = 1'b0;
            bit0_in = 1'b0;
        end
        checks++;
        if (done !== 1'b1 || regout !== data_a || bit_out !== 1'b0) begin
            failures++;
            $display("FAIL ign_done done=%b regout=%h bit_out=%b required 1/%h/0",
                     done, regout, bit_out, data_a);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || dout_valid !== 1'b0) begin
            failures++;
            $display("FAIL ign_no_restart busy=%b valid=%b required 0/0", busy, dout_valid);
        end
    endtask

    task automatic test_reset_mid();
        logic seen_done;
        do_load(data_a);
        dout_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        checks++;
        if (dout !== 16'h1005 || dout_valid !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_pre dout=%h valid=%b required 1005/1", dout, dout_valid);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if (dout_valid !== 1'b0 || busy !== 1'b0 || regout !== 256'd0 || done !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_state valid=%b busy=%b regout=%h done=%b required 0/0/0/0",
                     dout_valid, busy, regout, done);
        end
        seen_done = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done === 1'b1) seen_done = 1'b1;
        end
        checks++;
        if (seen_done !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_nodone done_seen=%b required 0", seen_done);
        end
        do_load(data_b);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (dout_valid !== 1'b1 || dout !== 16'(16'h2000 + k)) begin
                failures++;
                $display("FAIL rst_mid_fresh%0d dout=%h valid=%b required %h/1",
                         k, dout, dout_valid, 16'(16'h2000 + k));
            end
            tick();
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_fresh_done done=%b required 1", done);
        end
        tick();
    endtask

    task automatic test_load_start();
        do_load(data_a);
        din = data_b;
        load = 1'b1;
        start = 1'b1;
        tick();
        load = 1'b0;
        start = 1'b0;
        checks++;
        if (regout !== data_b || busy !== 1'b0 || dout_valid !== 1'b0) begin
            failures++;
            $display("FAIL ls_collide regout=%h busy=%b valid=%b required %h/0/0",
                     regout, busy, dout_valid, data_b);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (dout_valid !== 1'b1 || dout !== 16'(16'h2000 + k)) begin
                failures++;
                $display("FAIL ls_word%0d dout=%h valid=%b required %h/1",
                         k, dout, dout_valid, 16'(16'h2000 + k));
            end
            tick();
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL ls_done done=%b required 1", done);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        do_load(data_a);
        dout_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 16; k++) tick();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_first_done done=%b busy=%b required 1/0", done, busy);
        end
        // start accepted in the done cycle
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (dout_valid !== 1'b1 || done !== 1'b0 || dout !== 16'(16'h1000 + k)) begin
                failures++;
                $display("FAIL b2b_word%0d dout=%h valid=%b done=%b required %h/1/0",
                         k, dout, dout_valid, done, 16'(16'h1000 + k));
            end
            tick();
        end
        checks++;
        if (done !== 1'b1 || regout !== data_a) begin
            failures++;
            $display("FAIL b2b_done done=%b regout=%h required 1/%h", done, regout, data_a);
        end
        tick();
    endtask

    initial begin
        rst_n      = 1'b0;
        load       = 1'b0;
        din        = '0;
        start      = 1'b0;
        shl1       = 1'b0;
        bit0_in    = 1'b0;
        dout_ready = 1'b0;
        for (int k = 0; k < 16; k++) begin
            data_a[k*16 +: 16] = 16'(16'h1000 + k);
            data_b[k*16 +: 16] = 16'(16'h2000 + k);
        end

        test_reset();
        test_stream();
        test_backpressure();
        test_shl1();
        test_ignore_in_send();
        test_reset_mid();
        test_load_start();
        test_back_to_back();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
